// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MD_W     = 16;
  localparam int unsigned MD_CNT_W = $clog2(MD_W);

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         op,
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  input  logic [W-1:0] opnd,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  logic [W:0]   sum;
  logic [W:0]   rs;
  logic         ge;
  logic [W-1:0] rem;

  always_comb begin
    sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd} : '0);
    rs  = {hi_i, lo_i[W-1]};
    ge  = (rs >= {1'b0, opnd});
    // When rs >= opnd the difference is below opnd, so the low W bits are exact.
    rem = rs[W-1:0] - opnd;
    if (op == OP_MUL) begin
      hi_o = sum[W:1];
      lo_o = {sum[0], lo_i[W-1:1]};
    end else if (ge) begin
      hi_o = rem;
      lo_o = {lo_i[W-2:0], 1'b1};
    end else begin
      hi_o = rs[W-1:0];
      lo_o = {lo_i[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequenced unsigned multiply/divide with committed HI/LO and direct access.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         wr_hi,
  input  logic         wr_lo,
  input  logic [W-1:0] wdata,
  input  logic         rd_sel,
  output logic [W-1:0] rdata,
  output logic         busy,
  output logic         done,
  output logic         dz
);

  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  muldiv_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0] opnd_q, opnd_d;
  logic [W-1:0] wk_hi_q, wk_hi_d;
  logic [W-1:0] wk_lo_q, wk_lo_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         dz_q, dz_d;
  logic         dzp_q, dzp_d;
  logic [W-1:0] step_hi, step_lo;

  muldiv_step #(.W(W)) u_step (
    .op   ((state_q == DIV) ? OP_DIV : OP_MUL),
    .hi_i (wk_hi_q),
    .lo_i (wk_lo_q),
    .opnd (opnd_q),
    .hi_o (step_hi),
    .lo_o (step_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      wk_hi_q <= '0;
      wk_lo_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      dzp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      wk_hi_q <= wk_hi_d;
      wk_lo_q <= wk_lo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      dzp_q   <= dzp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    wk_hi_d = wk_hi_q;
    wk_lo_d = wk_lo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    dzp_d   = dzp_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        // An accepted start takes priority over any coincident direct write.
        if (start) begin
          state_d = (op == OP_MUL) ? MUL : DIV;
          cnt_d   = '0;
          dz_d    = 1'b0;
          wk_hi_d = '0;
          if (op == OP_MUL) begin
            wk_lo_d = b;
            opnd_d  = a;
            dzp_d   = 1'b0;
          end else begin
            wk_lo_d = a;
            opnd_d  = b;
            dzp_d   = (b == '0);
          end
        end else begin
          if (wr_hi) hi_d = wdata;
          if (wr_lo) lo_d = wdata;
        end
      end
      MUL, DIV: begin
        if (dzp_q) begin
          hi_d    = wk_lo_q;
          lo_d    = '1;
          dz_d    = 1'b1;
          dzp_d   = 1'b0;
          state_d = DONE;
        end else begin
          wk_hi_d = step_hi;
          wk_lo_d = step_lo;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            hi_d    = step_hi;
            lo_d    = step_lo;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == MUL) || (state_d == DIV);
    done_d = (state_d == DONE);
  end

  assign rdata = rd_sel ? hi_q : lo_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign dz    = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed scoreboard bench for muldiv_seq.
module tb_muldiv_seq;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start, op, wr_hi, wr_lo, rd_sel;
  logic [W-1:0] a, b, wdata, rdata;
  logic         busy, done, dz;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;

  muldiv_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .rd_sel(rd_sel),
    .rdata(rdata), .busy(busy), .done(done), .dz(dz)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic read_hilo(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el);
    rd_sel = 1'b1;
    #1 chk({tag, " hi"}, rdata, eh);
    rd_sel = 1'b0;
    #1 chk({tag, " lo"}, rdata, el);
  endtask

  // Drive a start for one cycle; optionally push the reference result.
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    exp_t e;
    logic [2*W-1:0] xx, yy, p;
    xx = {{W{1'b0}}, x};
    yy = {{W{1'b0}}, y};
    p  = xx * yy;
    if (o == 1'b0) begin
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
      e.dz = 1'b0;
    end else if (y == '0) begin
      e.hi = x;
      e.lo = '1;
      e.dz = 1'b1;
    end else begin
      e.hi = x % y;
      e.lo = x / y;
      e.dz = 1'b0;
    end
    if (push) sb.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    chk("busy after accept", W'(busy), W'(1));
    chk("dz cleared on start", W'(dz), W'(0));
  endtask

  // Wait (bounded) for done, check latency and pop/compare the result.
  task automatic wait_done(input string tag, input int n0, input int lat);
    int n;
    exp_t e;
    n = n0;
    while (!done && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, W'(n), W'(lat));
    if (!done) return;
    chk({tag, " busy low at done"}, W'(busy), W'(0));
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed done expected empty scoreboard entry", tag);
    end else begin
      e = sb.pop_front();
      mhi = e.hi;
      mlo = e.lo;
      read_hilo(tag, e.hi, e.lo);
      chk({tag, " dz"}, W'(dz), W'(e.dz));
    end
  endtask

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0; rd_sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", W'(busy), W'(0));
    chk("reset done", W'(done), W'(0));
    chk("reset dz", W'(dz), W'(0));
    read_hilo("reset", '0, '0);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 16'd3, 16'd5, 1'b1);
    wait_done("mul 3x5", 0, 16);
    read_hilo("mul 3x5 const", 16'h0000, 16'h000F);
    @(negedge clk);
    chk("done single cycle", W'(done), W'(0));
    chk("idle not busy", W'(busy), W'(0));

    issue(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    wait_done("mul max", 0, 16);
    issue(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    wait_done("mul max b2b", 0, 16);
    read_hilo("mul max const", 16'hFFFE, 16'h0001);
    @(negedge clk);

    issue(1'b1, 16'd100, 16'd7, 1'b1);
    wait_done("div 100/7", 0, 16);
    read_hilo("div 100/7 const", 16'd2, 16'd14);
    @(negedge clk);

    issue(1'b1, 16'h1234, 16'h0000, 1'b1);
    wait_done("div by zero", 0, 1);
    read_hilo("div by zero const", 16'h1234, 16'hFFFF);
    repeat (3) @(negedge clk);
    chk("dz holds", W'(dz), W'(1));

    wr_hi = 1'b1; wdata = 16'hABCD;
    @(negedge clk);
    wr_hi = 1'b0;
    mhi = 16'hABCD;
    read_hilo("wr_hi", mhi, mlo);

    issue(1'b0, 16'd2, 16'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; op = 1'b1; a = 16'd7; b = 16'd0;
      wr_lo = 1'b1; wdata = 16'h5555;
      read_hilo("busy holds hilo", mhi, mlo);
      @(negedge clk);
    end
    start = 1'b0; wr_lo = 1'b0;
    wait_done("mul 2x2", 3, 16);
    read_hilo("mul 2x2 const", 16'h0000, 16'h0004);
    @(negedge clk);
    chk("ignored start not queued", W'(busy), W'(0));

    issue(1'b1, 16'hFFFF, 16'd3, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort busy", W'(busy), W'(0));
    chk("abort done", W'(done), W'(0));
    read_hilo("abort", '0, '0);
    mhi = '0; mlo = '0;
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (24) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("no done after abort", W'(dcount), W'(0));

    issue(1'b1, 16'd9, 16'd3, 1'b1);
    wait_done("div 9/3", 0, 16);
    read_hilo("div 9/3 const", 16'd0, 16'd3);
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      issue(1'(i % 2), W'($urandom), W'($urandom_range(1, 65535)), 1'b1);
      wait_done("random op", 0, 16);
      @(negedge clk);
    end

    chk("scoreboard drained", W'(sb.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
